wbck_arb: RTL and testbench

- Write-back arbitration stage directly upstream of the general-purpose register file.
- Merges two result sources into the single register-file write port:
  - ALU/MUL single-cycle results.
  - LSU load results.
- Each source uses a valid/ready handshake. The LSU has priority, with a starvation guard for the ALU.
- The write command is registered: one write per cycle, at a fixed latency of 1 cycle.
- Also keeps a 32-bit retired-write counter.

---
 rtl/wbck_arb_if.sv | 37 +++
 rtl/wbck_arb.sv | 85 ++++++++
 tb/tb_wbck_arb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/wbck_arb_if.sv
// Write-back arbitration bus: ALU and LSU result sources plus the register-file write port.
interface wbck_arb_if #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned REG_IDX_WIDTH = 5
);
   logic                     alu_wb_valid_i;
   logic                     alu_wb_ready_o;
   logic                     alu_wb_rd_en_i;
   logic [REG_IDX_WIDTH-1:0] alu_wb_rd_idx_i;
   logic [XLEN-1:0]          alu_wb_wdata_i;

   logic                     lsu_wb_valid_i;
   logic                     lsu_wb_ready_o;
   logic [REG_IDX_WIDTH-1:0] lsu_wb_rd_idx_i;
   logic [XLEN-1:0]          lsu_wb_wdata_i;

   logic                     rd_en_o;
   logic [REG_IDX_WIDTH-1:0] rd_idx_o;
   logic [XLEN-1:0]          wdata_o;
   logic [31:0]              wb_cnt_o;

   // Arbiter side
   modport slave (
      input  alu_wb_valid_i, alu_wb_rd_en_i, alu_wb_rd_idx_i, alu_wb_wdata_i,
      input  lsu_wb_valid_i, lsu_wb_rd_idx_i, lsu_wb_wdata_i,
      output alu_wb_ready_o, lsu_wb_ready_o,
      output rd_en_o, rd_idx_o, wdata_o, wb_cnt_o
   );

   // Result-source / register-file side
   modport master (
      output alu_wb_valid_i, alu_wb_rd_en_i, alu_wb_rd_idx_i, alu_wb_wdata_i,
      output lsu_wb_valid_i, lsu_wb_rd_idx_i, lsu_wb_wdata_i,
      input  alu_wb_ready_o, lsu_wb_ready_o,
      input  rd_en_o, rd_idx_o, wdata_o, wb_cnt_o
   );
endinterface

// File: rtl/wbck_arb.sv
// Write-back arbiter: merges ALU and LSU results into one registered register-file
// write port. LSU has priority; the ALU wins after STARVE_LIMIT consecutive denials.
module wbck_arb #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned REG_IDX_WIDTH = 5,
   parameter int unsigned STARVE_LIMIT  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   wbck_arb_if.slave   bus
);
   localparam int unsigned CNT_W    = 32;
   localparam int unsigned STARVE_W = 4;

   logic [STARVE_W-1:0]      starve_cnt;
   logic                     starved_c;
   logic                     grant_lsu_c;
   logic                     grant_alu_c;
   logic                     xfer_c;
   logic                     sel_en_c;
   logic                     wr_en_c;
   logic [REG_IDX_WIDTH-1:0] sel_idx_c;
   logic [XLEN-1:0]          sel_data_c;

   logic                     rd_en_q;
   logic [REG_IDX_WIDTH-1:0] rd_idx_q;
   logic [XLEN-1:0]          wdata_q;
   logic [CNT_W-1:0]         wb_cnt_q;

   // Grant selection and payload mux
   always_comb begin
      starved_c   = (starve_cnt == STARVE_W'(STARVE_LIMIT));
      grant_lsu_c = bus.lsu_wb_valid_i & ~(bus.alu_wb_valid_i & starved_c);
      grant_alu_c = bus.alu_wb_valid_i & ~grant_lsu_c;
      xfer_c      = grant_lsu_c | grant_alu_c;
      sel_en_c    = bus.alu_wb_rd_en_i;
      sel_idx_c   = bus.alu_wb_rd_idx_i;
      sel_data_c  = bus.alu_wb_wdata_i;
      if (grant_lsu_c) begin
         sel_en_c   = 1'b1;
         sel_idx_c  = bus.lsu_wb_rd_idx_i;
         sel_data_c = bus.lsu_wb_wdata_i;
      end
      // x0 is hardwired zero: accept the result but never write it
      wr_en_c = sel_en_c & (sel_idx_c != '0);
   end

   // Ready is the grant, held low while reset is asserted
   assign bus.alu_wb_ready_o = grant_alu_c & rst_n;
   assign bus.lsu_wb_ready_o = grant_lsu_c & rst_n;

   // Count consecutive cycles the ALU waits behind the LSU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!bus.alu_wb_valid_i || grant_alu_c) begin
         starve_cnt <= '0;
      end else if (grant_lsu_c && (starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end

   // Registered write port and retired-write counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q  <= 1'b0;
         rd_idx_q <= '0;
         wdata_q  <= '0;
         wb_cnt_q <= '0;
      end else begin
         rd_en_q <= xfer_c & wr_en_c;
         if (xfer_c) begin
            rd_idx_q <= sel_idx_c;
            wdata_q  <= sel_data_c;
            wb_cnt_q <= wb_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.rd_en_o  = rd_en_q;
   assign bus.rd_idx_o = rd_idx_q;
   assign bus.wdata_o  = wdata_q;
   assign bus.wb_cnt_o = wb_cnt_q;

endmodule

// File: tb/tb_wbck_arb.sv
// Directed table-driven bench for the write-back arbiter.
module tb_wbck_arb;
   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   wbck_arb_if #(.XLEN(32), .REG_IDX_WIDTH(5)) bus ();

   wbck_arb #(.XLEN(32), .REG_IDX_WIDTH(5), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic        ae;
      logic [4:0]  ai;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  li;
      logic [31:0] ld;
      logic        ear;
      logic        elr;
      logic        een;
      logic [4:0]  eidx;
      logic [31:0] edat;
      logic [31:0] ecnt;
   } vec_t;

   vec_t tbl[$];

   // Source-rule bookkeeping: payload of a source left waiting last cycle
   logic        pend_a, pend_l;
   logic        prev_ae;
   logic [4:0]  prev_ai, prev_li;
   logic [31:0] prev_ad, prev_ld;

   function automatic vec_t mk(input logic av, input logic ae, input logic [4:0] ai,
                               input logic [31:0] ad, input logic lv, input logic [4:0] li,
                               input logic [31:0] ld, input logic ear, input logic elr,
                               input logic een, input logic [4:0] eidx,
                               input logic [31:0] edat, input logic [31:0] ecnt);
      vec_t v;
      v.av = av; v.ae = ae; v.ai = ai; v.ad = ad;
      v.lv = lv; v.li = li; v.ld = ld;
      v.ear = ear; v.elr = elr; v.een = een;
      v.eidx = eidx; v.edat = edat; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Contention burst: ALU holds idx 7, LSU streams idx 10.. ; ALU wins on the 5th cycle
   task automatic push_contention(input logic [31:0] base);
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(1, 1, 7, 32'h77, 1, 5'(10 + k), 32'h100 + 32'(k),
                          0, 1, 1, 5'(10 + k), 32'h100 + 32'(k), base + 32'(k + 1)));
      tbl.push_back(mk(1, 1, 7, 32'h77, 1, 14, 32'h104, 1, 0, 1, 7, 32'h77, base + 5));
      tbl.push_back(mk(1, 1, 8, 32'h88, 1, 14, 32'h104, 0, 1, 1, 14, 32'h104, base + 6));
      tbl.push_back(mk(1, 1, 8, 32'h88, 0, 0, 32'h0, 1, 0, 1, 8, 32'h88, base + 7));
   endtask

   task automatic drive(input vec_t v);
      bus.alu_wb_valid_i  = v.av;
      bus.alu_wb_rd_en_i  = v.ae;
      bus.alu_wb_rd_idx_i = v.ai;
      bus.alu_wb_wdata_i  = v.ad;
      bus.lsu_wb_valid_i  = v.lv;
      bus.lsu_wb_rd_idx_i = v.li;
      bus.lsu_wb_wdata_i  = v.ld;
   endtask

   // One cycle: drive at negedge, check ready before the edge, check outputs after it
   task automatic apply(input vec_t v, input string nm);
      @(negedge clk);
      if (pend_a)
         assert (v.av && v.ae == prev_ae && v.ai == prev_ai && v.ad == prev_ad)
            else $error("%s: ALU source changed while waiting", nm);
      if (pend_l)
         assert (v.lv && v.li == prev_li && v.ld == prev_ld)
            else $error("%s: LSU source changed while waiting", nm);
      drive(v);
      #1;
      chk({nm, " alu_ready"}, 32'(bus.alu_wb_ready_o), 32'(v.ear));
      chk({nm, " lsu_ready"}, 32'(bus.lsu_wb_ready_o), 32'(v.elr));
      pend_a  = v.av & ~v.ear;
      pend_l  = v.lv & ~v.elr;
      prev_ae = v.ae; prev_ai = v.ai; prev_ad = v.ad;
      prev_li = v.li; prev_ld = v.ld;
      @(posedge clk);
      #1;
      chk({nm, " rd_en"},  32'(bus.rd_en_o),  32'(v.een));
      chk({nm, " rd_idx"}, 32'(bus.rd_idx_o), 32'(v.eidx));
      chk({nm, " wdata"},  bus.wdata_o,       v.edat);
      chk({nm, " wb_cnt"}, bus.wb_cnt_o,      v.ecnt);
   endtask

   initial begin
      vec_t idle;
      pend_a = 1'b0; pend_l = 1'b0;
      prev_ae = 1'b0; prev_ai = '0; prev_ad = '0; prev_li = '0; prev_ld = '0;

      // Vector table
      tbl.push_back(mk(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1, 3, 32'hDEADBEEF, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 1, 0, 0, 32'hFFFF, 2));
      tbl.push_back(mk(1, 0, 9, 32'h55, 0, 0, 0, 1, 0, 0, 9, 32'h55, 3));
      tbl.push_back(mk(0, 0, 0, 0, 1, 20, 32'hA5A5, 0, 1, 1, 20, 32'hA5A5, 4));
      push_contention(4);
      tbl.push_back(mk(1, 1, 0, 32'h99, 0, 0, 0, 1, 0, 0, 0, 32'h99, 12));
      for (int k = 0; k < 10; k++)
         tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99, 12));
      push_contention(12);

      // Reset with valids present: readies held low, outputs cleared
      drive(mk(1, 1, 5, 32'h1234, 1, 6, 32'h4321, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset alu_ready", 32'(bus.alu_wb_ready_o), 0);
      chk("reset lsu_ready", 32'(bus.lsu_wb_ready_o), 0);
      chk("reset rd_en",     32'(bus.rd_en_o), 0);
      chk("reset rd_idx",    32'(bus.rd_idx_o), 0);
      chk("reset wdata",     bus.wdata_o, 0);
      chk("reset wb_cnt",    bus.wb_cnt_o, 0);
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      drive(idle);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("row%0d", i));

      // Counter wrap from a preloaded value
      @(negedge clk);
      drive(idle);
      force dut.wb_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.wb_cnt_q;
      apply(mk(1, 1, 1, 32'hA0, 0, 0, 0, 1, 0, 1, 1, 32'hA0, 32'hFFFF_FFFF), "wrap0");
      apply(mk(0, 0, 0, 0, 1, 2, 32'hA1, 0, 1, 1, 2, 32'hA1, 32'h0), "wrap1");
      apply(mk(1, 1, 3, 32'hA2, 0, 0, 0, 1, 0, 1, 3, 32'hA2, 32'h1), "wrap2");

      // Asynchronous reset while a write is in flight
      apply(mk(1, 1, 5, 32'h1234, 0, 0, 0, 1, 0, 1, 5, 32'h1234, 2), "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst rd_en",     32'(bus.rd_en_o), 0);
      chk("mid_rst wb_cnt",    bus.wb_cnt_o, 0);
      chk("mid_rst rd_idx",    32'(bus.rd_idx_o), 0);
      chk("mid_rst wdata",     bus.wdata_o, 0);
      chk("mid_rst alu_ready", 32'(bus.alu_wb_ready_o), 0);
      pend_a = 1'b0; pend_l = 1'b0;
      @(posedge clk);
      #1;
      chk("in_rst rd_en", 32'(bus.rd_en_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst alu_ready", 32'(bus.alu_wb_ready_o), 1);
      @(posedge clk);
      #1;
      chk("post_rst rd_en",  32'(bus.rd_en_o), 1);
      chk("post_rst rd_idx", 32'(bus.rd_idx_o), 5);
      chk("post_rst wdata",  bus.wdata_o, 32'h1234);
      chk("post_rst wb_cnt", bus.wb_cnt_o, 1);

      @(negedge clk);
      drive(idle);
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
